// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - shared RV32 core types for the writeback path
package rv_pkg;
  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_entry_t;
endpackage

// File: rtl/wb_arbiter_if.sv
// rtl/wb_arbiter_if.sv - writeback arbiter bus: ALU/long-latency results, scoreboard, regfile port
interface wb_arbiter_if #(parameter int XLEN = 32);
  logic            a_valid;
  logic [4:0]      a_rd;
  logic [XLEN-1:0] a_data;
  logic            a_stall;
  logic            b_valid;
  logic            b_ready;
  logic [4:0]      b_rd;
  logic [XLEN-1:0] b_data;
  logic            iss_valid;
  logic [4:0]      iss_rd;
  logic [4:0]      chk_rs1;
  logic [4:0]      chk_rs2;
  logic            busy_rs1;
  logic            busy_rs2;
  logic            rf_we;
  logic [4:0]      rf_wr;
  logic [XLEN-1:0] rf_wd;

  modport master (
    output a_valid, a_rd, a_data, b_valid, b_rd, b_data,
           iss_valid, iss_rd, chk_rs1, chk_rs2,
    input  a_stall, b_ready, busy_rs1, busy_rs2, rf_we, rf_wr, rf_wd
  );

  modport slave (
    input  a_valid, a_rd, a_data, b_valid, b_rd, b_data,
           iss_valid, iss_rd, chk_rs1, chk_rs2,
    output a_stall, b_ready, busy_rs1, busy_rs2, rf_we, rf_wr, rf_wd
  );
endinterface

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - synchronous FIFO for buffered long-latency results
module wb_fifo
  import rv_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = wb_entry_t,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  T              push_data_i,
  input  logic          pop_i,
  output T              head_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);
  T              mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop)      count_d = count_q + 1'b1;
    else if (do_pop && !do_push) count_d = count_q - 1'b1;
  end

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end
endmodule

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - merges ALU and long-latency results onto the regfile write port
// and tracks pending long-latency destinations for decode.
module wb_arbiter
  import rv_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter int  XLEN  = rv_pkg::XLEN,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic       clk,
  input  logic       rst,
  wb_arbiter_if.slave bus
);
  wb_entry_t       push_data, head;
  logic            full, empty, push, pop, sel_a;
  logic [CW-1:0]   count;
  logic [31:0]     pending_q, pending_d;
  logic            rf_we_q;
  logic [4:0]      rf_wr_q;
  logic [XLEN-1:0] rf_wd_q;

  assign push_data = '{rd: bus.b_rd, data: bus.b_data};

  wb_fifo #(.DEPTH(DEPTH), .T(wb_entry_t)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .push_data_i (push_data),
    .pop_i       (pop),
    .head_o      (head),
    .full_o      (full),
    .empty_o     (empty),
    .count_o     (count)
  );

  // Ready is a function of occupancy only: a same-cycle pop never frees a slot for a push.
  assign bus.b_ready  = (count != CW'(DEPTH)) && !rst;
  assign bus.a_stall  = full && !rst;
  assign bus.busy_rs1 = pending_q[bus.chk_rs1];
  assign bus.busy_rs2 = pending_q[bus.chk_rs2];
  assign bus.rf_we    = rf_we_q;
  assign bus.rf_wr    = rf_wr_q;
  assign bus.rf_wd    = rf_wd_q;

  // x0 results are accepted from B but never stored.
  assign push = bus.b_valid && bus.b_ready && (bus.b_rd != 5'd0);

  always_comb begin
    pop   = 1'b0;
    sel_a = 1'b0;
    if (full)                                    pop   = 1'b1;
    else if (bus.a_valid && bus.a_rd != 5'd0)    sel_a = 1'b1;
    else if (!empty)                             pop   = 1'b1;
  end

  // Clear first, then set, so a same-cycle issue to the popping register stays pending.
  always_comb begin
    pending_d = pending_q;
    if (pop) pending_d[head.rd] = 1'b0;
    if (bus.iss_valid && bus.iss_rd != 5'd0) pending_d[bus.iss_rd] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= '0;
      rf_we_q   <= 1'b0;
      rf_wr_q   <= '0;
      rf_wd_q   <= '0;
    end else begin
      pending_q <= pending_d;
      rf_we_q   <= pop || sel_a;
      if (pop) begin
        rf_wr_q <= head.rd;
        rf_wd_q <= head.data;
      end else if (sel_a) begin
        rf_wr_q <= bus.a_rd;
        rf_wd_q <= bus.a_data;
      end
    end
  end
endmodule
